// File: rtl/y86_fetch_seq.sv
// y86_fetch_seq: byte-serial instruction fetch for the SEQ Y86-64 core.
// Reads one byte per mem_req/mem_ack handshake and returns decoded fields with a one-cycle strobe.
module y86_fetch_seq #(
    parameter logic [63:0] MEM_SIZE = 64'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_valid,
    input  logic [63:0] pc,
    output logic        ready,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic        out_valid,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    // state | meaning
    // IDLE  | waiting for pc_valid, ready=1
    // BYTE0 | reading the icode/ifun byte at pc
    // REGS  | reading the rA/rB byte at pc+1
    // CONST | reading valC byte k (k=0..7)
    // DONE  | one-cycle out_valid, fields held
    typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, DONE} state_t;

    state_t      state;
    logic [63:0] pc_q;
    logic [2:0]  k;
    logic [63:0] nxt_addr;
    logic        nxt_oor;
    logic        pc_oor;
    logic [3:0]  rd_hi;
    logic [3:0]  rd_lo;
    logic        need_regs;
    logic        need_const_only;

    function automatic logic [63:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = 64'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 64'd2;
            4'h7, 4'h8:             instr_len = 64'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 64'd10;
            default:                instr_len = 64'd1;
        endcase
    endfunction

    // Every instruction's bytes are contiguous, so the next address is always the current one plus one.
    assign nxt_addr        = mem_addr + 64'd1;
    assign nxt_oor         = (nxt_addr >= MEM_SIZE);
    assign pc_oor          = (pc >= MEM_SIZE);
    assign rd_hi           = mem_rdata[7:4];
    assign rd_lo           = mem_rdata[3:0];
    assign need_regs       = rd_hi inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    assign need_const_only = rd_hi inside {4'h7, 4'h8};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            mem_req     <= 1'b0;
            mem_addr    <= 64'd0;
            out_valid   <= 1'b0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b1;
            imem_error  <= 1'b0;
            pc_q        <= 64'd0;
            k           <= 3'd0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_valid) begin
                        pc_q        <= pc;
                        k           <= 3'd0;
                        ready       <= 1'b0;
                        icode       <= 4'h0;
                        ifun        <= 4'h0;
                        rA          <= 4'hF;
                        rB          <= 4'hF;
                        valC        <= 64'd0;
                        valP        <= pc + 64'd1;
                        instr_valid <= 1'b1;
                        imem_error  <= 1'b0;
                        if (pc_oor) begin
                            imem_error <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            state    <= BYTE0;
                        end
                    end
                end
                BYTE0: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                        end else begin
                            icode       <= rd_hi;
                            ifun        <= rd_lo;
                            valP        <= pc_q + instr_len(rd_hi);
                            instr_valid <= (rd_hi < 4'hC);
                            if (need_regs || need_const_only) begin
                                if (nxt_oor) begin
                                    mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                                end else begin
                                    mem_addr <= nxt_addr;
                                    state    <= need_regs ? REGS : CONST;
                                end
                            end else begin
                                mem_req <= 1'b0; out_valid <= 1'b1; state <= DONE;
                            end
                        end
                    end
                end
                REGS: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                        end else begin
                            rA <= rd_hi;
                            rB <= rd_lo;
                            if (icode inside {4'h3, 4'h4, 4'h5}) begin
                                if (nxt_oor) begin
                                    mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                                end else begin
                                    mem_addr <= nxt_addr;
                                    k        <= 3'd0;
                                    state    <= CONST;
                                end
                            end else begin
                                mem_req <= 1'b0; out_valid <= 1'b1; state <= DONE;
                            end
                        end
                    end
                end
                CONST: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                        end else begin
                            valC[{k, 3'b000} +: 8] <= mem_rdata;
                            if (k == 3'd7) begin
                                mem_req <= 1'b0; out_valid <= 1'b1; state <= DONE;
                            end else if (nxt_oor) begin
                                mem_req <= 1'b0; imem_error <= 1'b1; out_valid <= 1'b1; state <= DONE;
                            end else begin
                                mem_addr <= nxt_addr;
                                k        <= k + 3'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
